// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read initiator that fetches the system ID
// (word 0) and timestamp (word 1) from a sysid responder. It compares both
// words against the values baked in at generation time and reports
// done/match/timeout.
// Optional build macro SYSID_CHECK_RETRY_EN: on a compare mismatch the
// sequence restarts up to MAX_RETRY times, and retry_count is exported.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd37,
  parameter logic [31:0] EXPECTED_TS    = 32'd1603647235,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SYSID_CHECK_RETRY_EN
  ,
  output logic [3:0]  retry_count
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ID_REQ, ID_RSP, TS_REQ, TS_RSP, FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tcnt;
  logic          is_req, is_rsp, id_phase, accept, cap, cap_ts;
  logic          expired, begin_seq, pass, retry;

  assign is_req    = (state == ID_REQ) || (state == TS_REQ);
  assign is_rsp    = (state == ID_RSP) || (state == TS_RSP);
  assign id_phase  = (state == ID_REQ) || (state == ID_RSP);
  assign accept    = is_req && !avm_waitrequest;
  // Data counts only in an RSP state, or together with the accept (zero latency).
  assign cap       = avm_readdatavalid && (is_rsp || accept);
  assign cap_ts    = cap && !id_phase;
  // Abort on the last allowed cycle of an access that has not completed.
  // A completing cycle always wins over the abort.
  assign expired   = (is_req || is_rsp) && !cap && (tcnt >= CW'(TIMEOUT_CYCLES - 1));
  assign begin_seq = start && ((state == IDLE) || (state == FIN));
  // id_value is already registered by the time the timestamp arrives.
  assign pass      = (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);

`ifdef SYSID_CHECK_RETRY_EN
  assign retry = cap_ts && !pass && (retry_count < 4'(MAX_RETRY));
`else
  assign retry = 1'b0;
`endif

  assign avm_read    = is_req;
  assign avm_address = (state == TS_REQ) || (state == TS_RSP);
  assign busy        = is_req || is_rsp;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: request, optional response wait, then the next word or FIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: if (start) state_nxt = ID_REQ;
      ID_REQ: begin
        if (expired)     state_nxt = FIN;
        else if (accept) state_nxt = avm_readdatavalid ? TS_REQ : ID_RSP;
      end
      ID_RSP: begin
        if (avm_readdatavalid) state_nxt = TS_REQ;
        else if (expired)      state_nxt = FIN;
      end
      TS_REQ: begin
        if (expired)     state_nxt = FIN;
        else if (accept) state_nxt = avm_readdatavalid ? (retry ? ID_REQ : FIN) : TS_RSP;
      end
      TS_RSP: begin
        if (avm_readdatavalid) state_nxt = retry ? ID_REQ : FIN;
        else if (expired)      state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured words, result flags, and the per-access timeout counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done     <= 1'b0;
      match    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
      tcnt     <= '0;
`ifdef SYSID_CHECK_RETRY_EN
      retry_count <= '0;
`endif
    end else if (begin_seq) begin
      done     <= 1'b0;
      match    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
      tcnt     <= '0;
`ifdef SYSID_CHECK_RETRY_EN
      retry_count <= '0;
`endif
    end else if (is_req || is_rsp) begin
      if (cap) begin
        tcnt <= '0;
        if (id_phase) begin
          id_value <= avm_readdata;
        end else if (retry) begin
          // A fresh attempt starts with no stale words.
          id_value <= '0;
          ts_value <= '0;
`ifdef SYSID_CHECK_RETRY_EN
          retry_count <= retry_count + 4'd1;
`endif
        end else begin
          ts_value <= avm_readdata;
          done     <= 1'b1;
          match    <= pass;
        end
      end else if (expired) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        match   <= 1'b0;
      end else if (tcnt != CW'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read initiator that queries a system-ID responder at boot or on demand.
- Reads word 0 (system ID) and word 1 (timestamp), latches both, and compares them against the expected values baked in at generation time.
- Sits beside the Nios subsystem. Raises done/match/timeout flags so reset-release logic or a status LED can gate on a correct hardware/software pairing.

Parameters:
- EXPECTED_ID, 32'd37, value required at word 0
- EXPECTED_TS, 32'd1603647235, value required at word 1
- TIMEOUT_CYCLES, 255, max cycles per access (request plus response) before abort; must be >= 1
- MAX_RETRY, 3, mismatch retries (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clock
- start  in  1  one-cycle pulse that begins a check sequence
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; request is accepted on a cycle where avm_read=1 and avm_waitrequest=0
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  readdata qualifier
- busy  out  1  sequence in progress
- done  out  1  sequence finished; held until next start
- match  out  1  both words equal expected; valid when done=1
- timeout  out  1  an access exceeded TIMEOUT_CYCLES; valid when done=1
- id_value  out  32  last captured word 0
- ts_value  out  32  last captured word 1

Behaviour:
- Reset: synchronous and active-low. While reset_n=0 at a rising edge, all outputs are 0, the FSM goes to IDLE, and the counters clear. Reset mid-sequence drops avm_read on the following edge. No partial results survive.
- FSM states: IDLE, ID_REQ, ID_RSP, TS_REQ, TS_RSP, FIN.
- IDLE: on start=1, go to ID_REQ. busy=1, done/match/timeout clear to 0, timeout counter clears.
- ID_REQ: avm_read=1, avm_address=0, held stable until accepted. On accept (waitrequest=0), go to ID_RSP and deassert avm_read next cycle.
- ID_RSP: on readdatavalid=1, capture avm_readdata into id_value, clear the counter, go to TS_REQ.
- Same-cycle response: if readdatavalid arrives in the same cycle as accept, data is captured and the FSM skips the RSP state, going straight to the next REQ state or to FIN.
- TS_REQ / TS_RSP: same as the ID states, with address=1 and capture into ts_value. Then go to FIN.
- FIN: busy=0, done=1, match=(id_value==EXPECTED_ID && ts_value==EXPECTED_TS). Registered, so done and match assert together one cycle after the ts capture. Start in FIN restarts the sequence exactly as from IDLE.
- Timeout: counter increments every cycle in REQ and RSP states and clears on each capture. When the count reaches TIMEOUT_CYCLES without completion: drop avm_read, go to FIN with timeout=1 and match=0. Captured values keep whatever was read so far; unread values are 0.
- Stray responses: readdatavalid outside an RSP state, or in the same cycle as an abort, is ignored.
- start while busy=1 is ignored.
- Counter width: clog2(TIMEOUT_CYCLES+1). It saturates and does not wrap.
- At most one outstanding read at a time.
- A response latency of 0 (same cycle as accept) is supported per the rule above.

Optional Feature:
- Macro: SYSID_CHECK_RETRY_EN.
- Defined: on a compare mismatch (not on timeout), restart at ID_REQ instead of finishing, up to MAX_RETRY times. A retry counter clears on start. The final FIN reports the result of the last attempt. An extra output retry_count [3:0] (reset 0) shows the attempts used.
- Undefined: a mismatch goes directly to FIN with match=0. retry_count is absent.

Test Plan:
- Zero-wait responder returning 37 / 1603647235, start pulse -> two reads at address 0 then 1; done=1, match=1, timeout=0; id_value=37, ts_value=1603647235.
- Responder asserts waitrequest for 5 cycles on each read -> avm_read and avm_address stay stable throughout; result is the same as above; busy is high from the cycle after start until done.
- Word 1 returns 0x12345678 -> done=1, match=0, ts_value=0x12345678. With SYSID_CHECK_RETRY_EN: 4 full read pairs, then retry_count=3, match=0.
- waitrequest held high permanently, TIMEOUT_CYCLES=16 -> avm_read drops after 16 cycles; done=1, timeout=1, match=0, id_value=0.
- reset_n driven low during TS_RSP, then released -> all outputs 0 and the FSM in IDLE; a late readdatavalid is ignored; a new start completes normally with match=1.
- start pulsed again while busy -> no effect on the sequence. start pulsed in FIN -> flags clear and a fresh sequence runs.
